task1_rom: RTL and testbench
============================

TASK1_ROM -- requirements
Module: task1_rom

Interface
REQ-001 The module SHALL have no parameters; depth is fixed at 1024 words and width at 10 bits.
REQ-002 The clk port SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-003 The reset port SHALL be an input, 1 bit wide, synchronous and active-high.
REQ-004 The address port SHALL be an input, 10 bits wide, and carries the instruction word address.
REQ-005 The read_data port SHALL be an output, 10 bits wide, and carries the registered instruction word.

Function
REQ-006 The block SHALL be a read-only program memory of 1024 x 10-bit words with no write path.
REQ-007 On each rising clk edge with reset low, read_data SHALL load the word stored at address.
REQ-008 Read latency SHALL be exactly one cycle: an address applied before edge N appears on read_data after edge N.
REQ-009 read_data SHALL hold its value between edges, independent of address changes.
REQ-010 All 1024 addresses SHALL be valid; there is no wrap-around or out-of-range case.
REQ-011 The contents SHALL implement the task-1 program f = x + y, with x at RAM[0], y at RAM[1] and the result at RAM[2], as listed below:
- 0: 0000000001 -- sub t0,t0,t0
- 1: 1101010000 -- load s0,0(s0)
- 2: 0000000000 -- nop (add t0,t0,t0)
- 3: 1101001000 -- load t1,0(s0)
- 4: 1101011001 -- load s1,1(s0)
- 5: 0000000000 -- nop
- 6: 0001101000 -- add t1,s1,t1
- 7: 1111001010 -- store t1,2(s0)
- 8: 0000000000 -- nop
- 9: 0010000010 -- halt
REQ-012 Addresses 10 to 1023 SHALL read 0000000000 (nop).
REQ-013 The contents SHALL be constant from time zero; they SHALL NOT depend on reset or on any simulation-only initialisation that differs from synthesis.

Reset
REQ-014 While reset is high at a rising clk edge, read_data SHALL become 0000000000.
REQ-015 Reset SHALL take priority over the read at the same edge.
REQ-016 The first read after reset deasserts SHALL take effect at the next rising edge, using the address present at that edge.
REQ-017 Before the first edge, read_data is undefined; no power-on value is required.

Structure
REQ-018 A shared package SHALL hold the word-width and depth constants.
REQ-019 The same package SHALL hold the named instruction constants: NOP = 0000000000, HALT = 0010000010, and the program length of 10 words.
REQ-020 The package SHALL also hold the register codes t0 = 00, t1 = 01, s0 = 10 and s1 = 11.
REQ-021 No sub-module SHALL be used; the contents SHALL be a single constant lookup (case table or constant array) feeding one output register.

Verification
REQ-022 Scenario 1: reset high for 2 cycles with address = 5 -> read_data = 0000000000 after each edge.
REQ-023 Scenario 2: release reset, then apply address 0, 1, 2 on successive cycles -> read_data shows 0000000001, 1101010000 and 0000000000, each one edge after its address is applied.
REQ-024 Scenario 3: sweep addresses 0 to 9 -> each read_data matches the REQ-011 table; address 9 returns 0010000010.
REQ-025 Scenario 4: apply addresses 10, 511 and 1023 -> read_data = 0000000000 for each.
REQ-026 Scenario 5: change address mid-cycle between edges -> read_data does not change until the next rising edge.
REQ-027 Scenario 6: assert reset at the same edge as address = 6 -> read_data = 0000000000, not 0001101000.

Source files
------------

// File: rtl/task1_rom_pkg.sv
// ---------------------------------------------------------------------------
// task1_rom_pkg
// Shared constants for the task-1 program ROM:
//   - word width, address width and depth of the program memory
//   - named instruction words (NOP, HALT) and the program length
//   - register field codes (t0, t1, s0, s1)
//   - program_word(): the constant contents lookup, one word per address
// ---------------------------------------------------------------------------
package task1_rom_pkg;

   localparam int WORD_W   = 10;
   localparam int ADDR_W   = 10;
   localparam int DEPTH    = 1024;
   localparam int PROG_LEN = 10;

   localparam logic [WORD_W-1:0] NOP  = 10'b0000000000;
   localparam logic [WORD_W-1:0] HALT = 10'b0010000010;

   typedef enum logic [1:0] {
      REG_T0 = 2'b00,
      REG_T1 = 2'b01,
      REG_S0 = 2'b10,
      REG_S1 = 2'b11
   } reg_code_t;

   // Program f = x + y with x at RAM[0], y at RAM[1], result to RAM[2].
   localparam logic [WORD_W-1:0] I_SUB_T0_T0_T0 = 10'b0000000001;
   localparam logic [WORD_W-1:0] I_LOAD_S0_0_S0 = 10'b1101010000;
   localparam logic [WORD_W-1:0] I_LOAD_T1_0_S0 = 10'b1101001000;
   localparam logic [WORD_W-1:0] I_LOAD_S1_1_S0 = 10'b1101011001;
   localparam logic [WORD_W-1:0] I_ADD_T1_S1_T1 = 10'b0001101000;
   localparam logic [WORD_W-1:0] I_STORE_T1_2S0 = 10'b1111001010;

   // Constant contents of the whole memory. Everything past the program
   // reads as NOP, so every one of the 1024 addresses is defined.
   function automatic logic [WORD_W-1:0] program_word(input logic [ADDR_W-1:0] addr);
      logic [WORD_W-1:0] word;
      word = NOP;
      case (addr)
         10'd0:   word = I_SUB_T0_T0_T0;  // sub t0,t0,t0 (clear t0)
         10'd1:   word = I_LOAD_S0_0_S0;  // load s0,0(s0)
         10'd2:   word = NOP;             // load-use delay slot
         10'd3:   word = I_LOAD_T1_0_S0;  // load t1,0(s0)  -> x
         10'd4:   word = I_LOAD_S1_1_S0;  // load s1,1(s0)  -> y
         10'd5:   word = NOP;             // load-use delay slot
         10'd6:   word = I_ADD_T1_S1_T1;  // add t1,s1,t1
         10'd7:   word = I_STORE_T1_2S0;  // store t1,2(s0) -> f
         10'd8:   word = NOP;
         10'd9:   word = HALT;
         default: word = NOP;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/task1_rom.sv
// ---------------------------------------------------------------------------
// task1_rom
// Read-only 1024 x 10-bit program memory holding the task-1 program.
// One-cycle registered read; no write path.
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high; clears read_data
//   address    in  10   instruction word address (all values valid)
//   read_data  out 10   registered instruction word
// ---------------------------------------------------------------------------
module task1_rom
   import task1_rom_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   output logic [WORD_W-1:0] read_data
);

   logic [WORD_W-1:0] read_data_next;

   // Contents are a pure function of the address, so they exist from time
   // zero and are unaffected by reset.
   always_comb begin
      read_data_next = program_word(address);
   end

   // Reset wins over the read at the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data <= '0;
      end else begin
         read_data <= read_data_next;
      end
   end

endmodule

// File: tb/tb_task1_rom.sv
// ---------------------------------------------------------------------------
// tb_task1_rom
// Scoreboard bench for task1_rom: stimulus pushes the expected word for the
// coming edge; an independent monitor pops and compares just after the edge
// and again late in the cycle (the output must hold while address moves).
// ---------------------------------------------------------------------------
module tb_task1_rom;

   logic       clk;
   logic       reset;
   logic [9:0] address;
   logic [9:0] read_data;

   typedef struct {
      logic [9:0] exp;
      int         addr;
      bit         rst;
   } sb_item_t;

   sb_item_t   sb[$];
   logic [9:0] ref_mem [1024];
   int         total;
   int         bad;
   int         issued;
   int         popped;

   task1_rom dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .read_data (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference contents straight from the program listing.
   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 10'b0000000000;
      ref_mem[0] = 10'b0000000001;
      ref_mem[1] = 10'b1101010000;
      ref_mem[2] = 10'b0000000000;
      ref_mem[3] = 10'b1101001000;
      ref_mem[4] = 10'b1101011001;
      ref_mem[5] = 10'b0000000000;
      ref_mem[6] = 10'b0001101000;
      ref_mem[7] = 10'b1111001010;
      ref_mem[8] = 10'b0000000000;
      ref_mem[9] = 10'b0010000010;
   end

   task automatic check(input string name, input sb_item_t e, input logic [9:0] got);
      total++;
      if (got !== e.exp) begin
         bad++;
         $display("FAIL %s addr=%0d rst=%0d got=%b want=%b", name, e.addr, e.rst, got, e.exp);
      end else begin
         $display("ok   %s addr=%0d rst=%0d data=%b", name, e.addr, e.rst, got);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and record what the next
   // rising edge must produce.
   task automatic step(input bit r, input int a);
      sb_item_t e;
      @(negedge clk);
      reset   = r;
      address = 10'(a);
      e.addr  = a;
      e.rst   = r;
      e.exp   = r ? 10'b0000000000 : ref_mem[a];
      sb.push_back(e);
      issued++;
   endtask

   // Monitor: compare right after each edge, then again just before the next
   // edge to confirm the output held.
   initial begin
      sb_item_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            popped++;
            check("read", e, read_data);
            #7;
            check("hold", e, read_data);
         end
      end
   end

   initial begin
      total   = 0;
      bad     = 0;
      issued  = 0;
      popped  = 0;
      reset   = 1'b1;
      address = 10'd5;

      // Scenario 1: reset held two cycles with address 5.
      step(1, 5);
      step(1, 5);
      // Scenario 2: release and read 0,1,2.
      step(0, 0);
      step(0, 1);
      step(0, 2);
      // Scenario 3: sweep the program.
      for (int a = 0; a < 10; a++) step(0, a);
      // Scenario 4: NOP region and the top address.
      step(0, 10);
      step(0, 511);
      step(0, 1023);
      // Scenario 5: wiggle address after the edge; output must not move.
      step(0, 9);
      @(posedge clk);
      #2 address = 10'd700;
      #1 address = 10'd4;
      #1 address = 10'd6;
      step(0, 6);
      // Scenario 6: reset at the same edge as address 6.
      step(1, 6);
      step(0, 7);
      // Randomized traffic, biased toward the program region.
      for (int n = 0; n < 200; n++) begin
         int a;
         a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15))
                                         : int'($urandom_range(0, 1023));
         step(($urandom_range(0, 15) == 0), a);
      end

      repeat (3) @(posedge clk);
      #9;
      total++;
      if (sb.size() != 0 || popped != issued) begin
         bad++;
         $display("FAIL drain left=%0d popped=%0d want=%0d", sb.size(), popped, issued);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
